// File: rtl/pic_stream_tx_pkg.sv
// Shared definitions for the picture stream transmitter: FSM state encodings,
// parameter defaults and the image-size / address-width derivations.
package pic_stream_tx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FSTART = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_FLUSH  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam int DEFAULT_DSIZE        = 8;
    localparam int DEFAULT_IMAGE_WIDTH  = 256;
    localparam int DEFAULT_IMAGE_LENGTH = 256;

    function automatic int image_size(input int width, input int length);
        return width * length;
    endfunction

    // A one-pixel image still needs a one-bit address bus.
    function automatic int addr_width(input int width, input int length);
        return (width * length > 1) ? $clog2(width * length) : 1;
    endfunction

endpackage

// File: rtl/pic_addr_gen.sv
// Raster address counter with clear, enable and last-address flag; shared by
// the frame-store reader and writer.
module pic_addr_gen #(
    parameter int ASIZE     = 16,
    parameter int LAST_ADDR = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [ASIZE-1:0] addr,
    output logic             last
);

    assign last = (addr == ASIZE'(LAST_ADDR));

    // Saturates on the last address so a frame can never wrap back to 0.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            addr <= '0;
        end else if (en && !last) begin
            addr <= addr + ASIZE'(1);
        end
    end

endmodule

// File: rtl/pic_stream_tx.sv
// Streams one raster-order frame from a 1-cycle-latency RAM into the 3x3 line
// buffer interface. Optional feature macro: CHECKSUM_EN adds a beat checksum port.
module pic_stream_tx
    import pic_stream_tx_pkg::*;
#(
    parameter int  DSIZE        = DEFAULT_DSIZE,
    parameter int  IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
    parameter int  IMAGE_LENGTH = DEFAULT_IMAGE_LENGTH,
    parameter int  FLUSH_CYCLES = IMAGE_WIDTH + 2,
    localparam int IMAGE_SIZE   = image_size(IMAGE_WIDTH, IMAGE_LENGTH),
    localparam int ASIZE        = addr_width(IMAGE_WIDTH, IMAGE_LENGTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             rd_en,
    output logic [ASIZE-1:0] rd_addr,
    input  logic [DSIZE-1:0] rd_data,
    output logic             frame_start,
    output logic             shift,
    output logic [DSIZE-1:0] sr_in,
    output logic             busy,
    output logic             done
`ifdef CHECKSUM_EN
    ,
    output logic [DSIZE+ASIZE-1:0] checksum
`endif
);

    localparam int FCW = $clog2(FLUSH_CYCLES + 1);

    logic [2:0]     state;
    logic           rd_valid;
    logic [FCW-1:0] flush_cnt;
    logic           addr_last;
    logic           launch;
    logic           addr_en;
    logic           kill;

    assign launch  = (state == ST_IDLE) && start && !abort;
    assign kill    = abort && (state != ST_IDLE);
    assign addr_en = rd_en && !kill;

    pic_addr_gen #(
        .ASIZE     (ASIZE),
        .LAST_ADDR (IMAGE_SIZE - 1)
    ) u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (launch),
        .en    (addr_en),
        .addr  (rd_addr),
        .last  (addr_last)
    );

    // rd_valid marks the cycle RAM data is present; shift follows one cycle
    // later so the beat stream is exactly the rd_en pattern delayed by two.
    always_ff @(posedge clk) begin
        if (!rst_n || kill) begin
            state       <= ST_IDLE;
            rd_en       <= 1'b0;
            rd_valid    <= 1'b0;
            frame_start <= 1'b0;
            shift       <= 1'b0;
            sr_in       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            flush_cnt   <= '0;
        end else begin
            frame_start <= 1'b0;
            done        <= 1'b0;
            rd_valid    <= rd_en;
            shift       <= rd_valid;
            sr_in       <= rd_valid ? rd_data : '0;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state       <= ST_FSTART;
                        frame_start <= 1'b1;
                        rd_en       <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                ST_FSTART: begin
                    state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (addr_last) begin
                        rd_en <= 1'b0;
                    end
                    // Last beat on the wire with nothing behind it in the pipe.
                    if (shift && !rd_valid) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == FCW'(FLUSH_CYCLES - 1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + FCW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CHECKSUM_EN
    // Wide enough for IMAGE_SIZE maximum pixels, so it cannot overflow.
    always_ff @(posedge clk) begin
        if (!rst_n || launch) begin
            checksum <= '0;
        end else if (shift) begin
            checksum <= checksum + (DSIZE+ASIZE)'(sr_in);
        end
    end
`endif

endmodule

// File: tb/tb_pic_stream_tx.sv
// Self-checking bench for pic_stream_tx on a 4x4 image with a 6-cycle flush;
// expected waveforms come from a cycle-indexed model of the frame timeline.
`timescale 1ns/1ps
module tb_pic_stream_tx;

    localparam int DSIZE  = 8;
    localparam int W      = 4;
    localparam int L      = 4;
    localparam int FLUSH  = 6;
    localparam int NPIX   = W * L;
    localparam int ASIZE  = 4;
    localparam int DONE_C = 2 + NPIX + FLUSH + 1;
    localparam int VW     = ASIZE + DSIZE + 5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic             rd_en;
    logic [ASIZE-1:0] rd_addr;
    logic [DSIZE-1:0] rd_data;
    logic             frame_start;
    logic             shift;
    logic [DSIZE-1:0] sr_in;
    logic             busy;
    logic             done;
`ifdef CHECKSUM_EN
    logic [DSIZE+ASIZE-1:0] checksum;
`endif

    logic [DSIZE-1:0] ram [NPIX];

    int tests = 0;
    int fails = 0;

    pic_stream_tx #(
        .DSIZE        (DSIZE),
        .IMAGE_WIDTH  (W),
        .IMAGE_LENGTH (L),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_start (frame_start),
        .shift       (shift),
        .sr_in       (sr_in),
        .busy        (busy),
        .done        (done)
`ifdef CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial rd_data = '0;
    always @(posedge clk) begin
        if (rd_en === 1'b1) rd_data <= ram[rd_addr];
    end

    // Expected outputs in cycle c after the edge that accepted start;
    // after an abort or reset taken at the end of cycle abort_at everything is 0.
    function automatic logic [VW-1:0] model(input int c, input int abort_at);
        logic fs, re, sh, bz, dn;
        logic [ASIZE-1:0] ad;
        logic [ASIZE-1:0] idx;
        logic [DSIZE-1:0] px;
        fs  = (c == 1);
        re  = (c >= 1) && (c <= NPIX);
        ad  = re ? ASIZE'(c - 1) : '0;
        sh  = (c >= 3) && (c < NPIX + 3);
        idx = ASIZE'(c - 3);
        px  = sh ? ram[idx] : '0;
        bz  = (c >= 1) && (c <= DONE_C);
        dn  = (c == DONE_C);
        if (abort_at > 0 && c > abort_at) return '0;
        return {fs, re, ad, sh, px, bz, dn};
    endfunction

    function automatic logic [VW-1:0] observed();
        logic [ASIZE-1:0] ad;
        ad = (rd_en === 1'b1) ? rd_addr : '0;
        return {frame_start, rd_en, ad, shift, sr_in, busy, done};
    endfunction

    function automatic int sum_ram();
        int s = 0;
        for (int i = 0; i < NPIX; i++) s += int'(ram[i]);
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ram_ramp();
        for (int i = 0; i < NPIX; i++) ram[i] = DSIZE'(i + 16);
    endtask

    task automatic fill_ram_random();
        for (int i = 0; i < NPIX; i++) ram[i] = DSIZE'($urandom);
    endtask

    task automatic launch_frame();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [VW-1:0] obs_v;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            obs_v = {frame_start, rd_en, rd_addr, shift, sr_in, busy, done};
            tests++;
            if (obs_v !== '0) begin
                fails++;
                $display("[TB] FAIL reset cycle %0d: got %h, expected 0", c, obs_v);
            end
`ifdef CHECKSUM_EN
            tests++;
            if (checksum !== '0) begin
                fails++;
                $display("[TB] FAIL reset_checksum: got %0d, expected 0", checksum);
            end
`endif
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_normal_frame();
        logic [VW-1:0] obs_v, exp_v;
        fill_ram_ramp();
        step();
        launch_frame();
        for (int c = 1; c <= DONE_C + 2; c++) begin
            obs_v = observed();
            exp_v = model(c, 0);
            tests++;
            if (obs_v !== exp_v) begin
                fails++;
                $display("[TB] FAIL normal cycle %0d: got %h, expected %h", c, obs_v, exp_v);
            end
`ifdef CHECKSUM_EN
            if (c >= NPIX + 3) begin
                tests++;
                if (checksum !== 12'd376) begin
                    fails++;
                    $display("[TB] FAIL normal_checksum cycle %0d: got %0d, expected 376", c, checksum);
                end
            end
`endif
            step();
        end
    endtask

    task automatic test_start_ignored();
        logic [VW-1:0] obs_v, exp_v;
        int beats = 0;
        int dones = 0;
        fill_ram_random();
        launch_frame();
        for (int c = 1; c <= DONE_C + 2; c++) begin
            obs_v = observed();
            exp_v = model(c, 0);
            tests++;
            if (obs_v !== exp_v) begin
                fails++;
                $display("[TB] FAIL start_ignored cycle %0d: got %h, expected %h", c, obs_v, exp_v);
            end
            if (shift === 1'b1) beats++;
            if (done === 1'b1) dones++;
`ifdef CHECKSUM_EN
            if (c == 1 || c == NPIX + 3) begin
                tests++;
                if (checksum !== (c == 1 ? 0 : sum_ram())) begin
                    fails++;
                    $display("[TB] FAIL start_ignored_checksum cycle %0d: got %0d, expected %0d",
                             c, checksum, (c == 1 ? 0 : sum_ram()));
                end
            end
`endif
            if (c == 10) start = 1'b1;
            step();
            start = 1'b0;
        end
        tests++;
        if (beats != NPIX) begin
            fails++;
            $display("[TB] FAIL start_ignored_beats: got %0d, expected %0d", beats, NPIX);
        end
        tests++;
        if (dones != 1) begin
            fails++;
            $display("[TB] FAIL start_ignored_done: got %0d pulses, expected 1", dones);
        end
    endtask

    task automatic test_abort();
        logic [VW-1:0] obs_v, exp_v;
        int dones = 0;
        fill_ram_random();
        launch_frame();
        for (int c = 1; c <= DONE_C + 2; c++) begin
            obs_v = observed();
            exp_v = model(c, 8);
            tests++;
            if (obs_v !== exp_v) begin
                fails++;
                $display("[TB] FAIL abort cycle %0d: got %h, expected %h", c, obs_v, exp_v);
            end
            if (done === 1'b1) dones++;
            if (c == 8) abort = 1'b1;
            step();
            abort = 1'b0;
        end
        tests++;
        if (dones != 0) begin
            fails++;
            $display("[TB] FAIL abort_done: got %0d pulses, expected 0", dones);
        end
        fill_ram_random();
        launch_frame();
        for (int c = 1; c <= DONE_C + 1; c++) begin
            obs_v = observed();
            exp_v = model(c, 0);
            tests++;
            if (obs_v !== exp_v) begin
                fails++;
                $display("[TB] FAIL after_abort cycle %0d: got %h, expected %h", c, obs_v, exp_v);
            end
            step();
        end
    endtask

    task automatic test_start_abort_idle();
        logic [VW-1:0] obs_v;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            obs_v = observed();
            tests++;
            if (obs_v !== '0) begin
                fails++;
                $display("[TB] FAIL start_abort_idle cycle %0d: got %h, expected 0", c, obs_v);
            end
            step();
        end
    endtask

    task automatic test_reset_midframe();
        logic [VW-1:0] obs_v, exp_v;
        int beats = 0;
        fill_ram_random();
        launch_frame();
        for (int c = 1; c <= 18; c++) begin
            obs_v = observed();
            exp_v = model(c, 12);
            tests++;
            if (obs_v !== exp_v) begin
                fails++;
                $display("[TB] FAIL reset_midframe cycle %0d: got %h, expected %h", c, obs_v, exp_v);
            end
            if (c == 12) rst_n = 1'b0;
            if (c == 14) rst_n = 1'b1;
            step();
        end
        fill_ram_random();
        launch_frame();
        for (int c = 1; c <= DONE_C + 1; c++) begin
            obs_v = observed();
            exp_v = model(c, 0);
            tests++;
            if (obs_v !== exp_v) begin
                fails++;
                $display("[TB] FAIL after_reset cycle %0d: got %h, expected %h", c, obs_v, exp_v);
            end
            if (shift === 1'b1) beats++;
            step();
        end
        tests++;
        if (beats != NPIX) begin
            fails++;
            $display("[TB] FAIL after_reset_beats: got %0d, expected %0d", beats, NPIX);
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] obs_v, exp_v;
        int period;
        period = DONE_C + 1;
        fill_ram_random();
        start = 1'b1;
        step();
        for (int c = 1; c <= 2 * period + 1; c++) begin
            obs_v = observed();
            exp_v = (c <= period) ? model(c, 0) : model(c - period, 0);
            tests++;
            if (obs_v !== exp_v) begin
                fails++;
                $display("[TB] FAIL back_to_back cycle %0d: got %h, expected %h", c, obs_v, exp_v);
            end
            if (c == period + 1) start = 1'b0;
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_random_frames();
        logic [VW-1:0] obs_v, exp_v;
        int gap, ab;
        for (int f = 0; f < 4; f++) begin
            fill_ram_random();
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step();
            ab = ($urandom_range(0, 1) == 1) ? $urandom_range(2, DONE_C - 1) : 0;
            launch_frame();
            for (int c = 1; c <= DONE_C + 3; c++) begin
                obs_v = observed();
                exp_v = model(c, ab);
                tests++;
                if (obs_v !== exp_v) begin
                    fails++;
                    $display("[TB] FAIL random frame %0d cycle %0d (abort_at %0d): got %h, expected %h",
                             f, c, ab, obs_v, exp_v);
                end
                if (c == ab) abort = 1'b1;
                step();
                abort = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        fill_ram_ramp();
        test_reset();
        test_normal_frame();
        test_start_ignored();
        test_abort();
        test_start_abort_idle();
        test_reset_midframe();
        test_back_to_back();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
